ps2_cmd_scheduler: RTL and testbench
====================================

Name: ps2_cmd_scheduler

Overview:
- Host-to-keyboard command sequencer sitting between the PS/2 receiver/transmitter pair and the scan-code decoder.
- Arbitrates three command requesters: keyboard reset, LED update and typematic rate. It serialises each command as command byte, then optional argument, onto the transmitter, and waits for the device ACK.
- Handles RESEND, timeout, bounded retry and the reset self-test reply.
- Filters protocol reply bytes so that only scan codes reach the downstream decoder.

Parameters:
- TIMEOUT_CYCLES, 2000000, clk cycles to wait for a device reply byte (20 ms at 100 MHz).
- BAT_TIMEOUT_CYCLES, 100000000, clk cycles to wait for the self-test result after a reset ACK.
- MAX_RETRY, 3, resends allowed per byte before the command is aborted.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_done  in  1  one-cycle strobe: received byte valid.
- rx_data  in  8  received byte.
- tx_busy  in  1  transmitter busy.
- tx_done  in  1  one-cycle strobe: byte fully sent.
- tx_start  out  1  one-cycle strobe: send tx_data.
- tx_data  out  8  byte to send; held stable from tx_start until tx_done.
- req_reset  in  1  pulse: request keyboard reset (0xFF).
- req_led  in  1  pulse: request LED update (0xED + arg).
- led_state  in  3  {Caps, Num, Scroll}; sampled at grant.
- req_rate  in  1  pulse: request typematic set (0xF3 + arg).
- rate_data  in  8  typematic argument; sampled at grant.
- fwd_valid  out  1  one-cycle strobe: scan-code byte for the decoder.
- fwd_data  out  8  forwarded byte.
- busy  out  1  high while any state is other than IDLE.
- cmd_done  out  1  one-cycle pulse: command completed OK.
- cmd_err  out  1  one-cycle pulse: command aborted (retries exhausted or BAT fail).

Behaviour:
- Reset values:
  - All outputs are 0.
  - All pending flags are cleared.
  - Retry counter and timeout counter are 0.
  - FSM is in IDLE.
- A reset asserted mid-command aborts immediately. No cmd_done or cmd_err pulse is produced.
- Pending flags:
  - Each req_* pulse sets its own pending bit.
  - A pending bit is cleared on grant.
  - If a req pulse arrives in the same cycle its bit is being cleared, the bit stays set.
- Arbitration:
  - Evaluated in IDLE only, with fixed priority reset > led > rate.
  - On grant, the command byte and argument are latched:
    - reset: 0xFF, no argument.
    - led: 0xED, then {5'b0, led_state}.
    - rate: 0xF3, then rate_data.
  - The retry counter is cleared on grant.
- FSM states and transitions:
  - IDLE -> SEND when any pending bit is set.
  - SEND:
    - If tx_busy=0, pulse tx_start with the current byte and go to WAIT_TX.
    - Otherwise stay in SEND.
  - WAIT_TX -> WAIT_ACK on tx_done. The timeout counter is loaded with TIMEOUT_CYCLES.
  - WAIT_ACK, on rx_done with 0xFA:
    - If an argument is still unsent, select it, clear the retry counter and go to SEND.
    - Else, for a reset command, load BAT_TIMEOUT_CYCLES and go to WAIT_BAT.
    - Else go to DONE.
  - WAIT_ACK, on rx_done with 0xFE or on timeout expiry:
    - If retries < MAX_RETRY, increment retries and go to SEND, resending the same byte.
    - Otherwise go to FAIL.
  - WAIT_BAT:
    - 0xAA -> DONE.
    - 0xFC, or timeout expiry -> FAIL.
  - DONE: pulse cmd_done, then go to IDLE.
  - FAIL: pulse cmd_err, then go to IDLE.
  - Each DONE/FAIL lasts exactly 1 cycle. Pending requests are serviced on the following IDLE cycle.
- Timeout counter:
  - Decrements every cycle in WAIT_ACK and WAIT_BAT.
  - Expiry is the cycle the count reaches 0.
  - Width is $clog2(max(TIMEOUT_CYCLES, BAT_TIMEOUT_CYCLES)+1).
  - If rx_done arrives in the expiry cycle, the received byte takes precedence over the timeout.
- Forwarding:
  - Bytes are consumed, never forwarded, in these cases only:
    - 0xFA or 0xFE received in WAIT_ACK.
    - 0xAA or 0xFC received in WAIT_BAT.
  - Every other rx_done byte, in any state, is forwarded: fwd_valid/fwd_data are registered one cycle after rx_done. This includes 0xF0 and 0xE0 prefixes and any 0xFA received in IDLE.
  - Latency is exactly 1 cycle. Back-to-back rx_done strobes are all forwarded.
- tx_start never asserts while tx_busy=1, and never twice without an intervening tx_done.
- A tx_done outside WAIT_TX is ignored.

Test Plan:
- LED update: req_led with led_state=3'b101. Expect tx_start with 0xED; after tx_done, rx 0xFA; then tx_start with 0x05; after tx_done, rx 0xFA. Expect one cmd_done pulse and no fwd_valid for either 0xFA.
- Priority and hold: req_led and req_reset in the same cycle. Expect 0xFF sent first, then rx 0xFA and 0xAA, then cmd_done. The 0xED sequence starts on the next IDLE cycle. A req_rate arriving mid-command is serviced after the LED command.
- Resend: on 0xF3 reply 0xFE three times, each followed by resend of 0xF3, then 0xFA; then argument 0x20 is sent and ACKed, giving cmd_done. With a fourth 0xFE instead, expect cmd_err and return to IDLE.
- Timeout: TIMEOUT_CYCLES=100, no reply after tx_done. Expect resend of the same byte every 100 cycles, 4 transmissions in total, then cmd_err.
- Forwarding: in IDLE, rx 0x1D, 0xF0, 0x1D and 0xFA. Expect all four on fwd_data, each one cycle after its rx_done. Scan code 0x1C received during WAIT_ACK is also forwarded.
- Reset mid-operation: assert reset in WAIT_ACK. Expect busy=0 and no cmd pulse; pending flags cleared; after release, no transmission until a new req pulse.

Source files
------------

// File: rtl/ps2_cmd_scheduler.sv
// Host-to-keyboard PS/2 command sequencer: arbitrates reset/LED/typematic requests,
// drives the transmitter byte by byte, handles ACK/RESEND/timeout/BAT and filters replies.
module ps2_cmd_scheduler #(
    parameter int TIMEOUT_CYCLES     = 2000000,
    parameter int BAT_TIMEOUT_CYCLES = 100000000,
    parameter int MAX_RETRY          = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       req_reset,
    input  logic       req_led,
    input  logic [2:0] led_state,
    input  logic       req_rate,
    input  logic [7:0] rate_data,
    output logic       fwd_valid,
    output logic [7:0] fwd_data,
    output logic       busy,
    output logic       cmd_done,
    output logic       cmd_err
);

    localparam int TMO_MAX = (TIMEOUT_CYCLES > BAT_TIMEOUT_CYCLES) ? TIMEOUT_CYCLES
                                                                   : BAT_TIMEOUT_CYCLES;
    localparam int TW = $clog2(TMO_MAX + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TW-1:0] TMO_LOAD    = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] BAT_LOAD    = TW'(BAT_TIMEOUT_CYCLES);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_LED      = 8'hED;
    localparam logic [7:0] CMD_RATE     = 8'hF3;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_TX,
        S_WAIT_ACK,
        S_WAIT_BAT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    pend_q, pend_d;         // {reset, led, rate}
    logic [7:0]    cmd_byte_q, cmd_byte_d;
    logic [7:0]    arg_byte_q, arg_byte_d;
    logic          has_arg_q, has_arg_d;
    logic          is_reset_q, is_reset_d;
    logic          arg_phase_q, arg_phase_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          fwd_valid_q, fwd_valid_d;
    logic [7:0]    fwd_data_q, fwd_data_d;
    logic          busy_q, busy_d;
    logic          cmd_done_q, cmd_done_d;
    logic          cmd_err_q, cmd_err_d;

    logic [2:0]    grant_clr;
    logic          consume;
    logic          tmo_zero;
    logic [7:0]    cur_byte;

    assign tmo_zero = (tmo_q == TW'(0));
    assign cur_byte = arg_phase_q ? arg_byte_q : cmd_byte_q;

    // Next-state, command latching, retry/timeout bookkeeping and reply filtering
    always_comb begin
        state_d     = state_q;
        cmd_byte_d  = cmd_byte_q;
        arg_byte_d  = arg_byte_q;
        has_arg_d   = has_arg_q;
        is_reset_d  = is_reset_q;
        arg_phase_d = arg_phase_q;
        retry_d     = retry_q;
        tmo_d       = tmo_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        fwd_valid_d = 1'b0;
        fwd_data_d  = fwd_data_q;
        grant_clr   = 3'b000;
        consume     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pend_q != 3'b000) begin
                    state_d     = S_SEND;
                    retry_d     = RW'(0);
                    arg_phase_d = 1'b0;
                    if (pend_q[2]) begin
                        grant_clr  = 3'b100;
                        cmd_byte_d = CMD_RESET;
                        arg_byte_d = 8'h00;
                        has_arg_d  = 1'b0;
                        is_reset_d = 1'b1;
                    end else if (pend_q[1]) begin
                        grant_clr  = 3'b010;
                        cmd_byte_d = CMD_LED;
                        arg_byte_d = {5'b00000, led_state};
                        has_arg_d  = 1'b1;
                        is_reset_d = 1'b0;
                    end else begin
                        grant_clr  = 3'b001;
                        cmd_byte_d = CMD_RATE;
                        arg_byte_d = rate_data;
                        has_arg_d  = 1'b1;
                        is_reset_d = 1'b0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_SEND: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = cur_byte;
                    state_d    = S_WAIT_TX;
                end else begin
                    state_d = S_SEND;
                end
            end

            S_WAIT_TX: begin
                if (tx_done) begin
                    state_d = S_WAIT_ACK;
                    tmo_d   = TMO_LOAD;
                end else begin
                    state_d = S_WAIT_TX;
                end
            end

            S_WAIT_ACK: begin
                if (rx_done && (rx_data == RSP_ACK)) begin
                    consume = 1'b1;
                    if (has_arg_q && !arg_phase_q) begin
                        arg_phase_d = 1'b1;
                        retry_d     = RW'(0);
                        state_d     = S_SEND;
                    end else if (is_reset_q) begin
                        tmo_d   = BAT_LOAD;
                        state_d = S_WAIT_BAT;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if ((rx_done && (rx_data == RSP_RESEND)) || (!rx_done && tmo_zero)) begin
                    // A received byte in the expiry cycle wins; expiry is retried next cycle
                    consume = rx_done;
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + RW'(1);
                        state_d = S_SEND;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else if (!tmo_zero) begin
                    tmo_d = tmo_q - TW'(1);
                end else begin
                    tmo_d = tmo_q;
                end
            end

            S_WAIT_BAT: begin
                if (rx_done && (rx_data == RSP_BAT_OK)) begin
                    consume = 1'b1;
                    state_d = S_DONE;
                end else if (rx_done && (rx_data == RSP_BAT_FAIL)) begin
                    consume = 1'b1;
                    state_d = S_FAIL;
                end else if (!rx_done && tmo_zero) begin
                    state_d = S_FAIL;
                end else if (!tmo_zero) begin
                    tmo_d = tmo_q - TW'(1);
                end else begin
                    tmo_d = tmo_q;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_FAIL: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (rx_done && !consume) begin
            fwd_valid_d = 1'b1;
            fwd_data_d  = rx_data;
        end else begin
            fwd_valid_d = 1'b0;
        end

        // A request arriving in its own grant cycle survives the clear
        pend_d     = (pend_q & ~grant_clr) | {req_reset, req_led, req_rate};
        busy_d     = (state_d != S_IDLE);
        cmd_done_d = (state_d == S_DONE);
        cmd_err_d  = (state_d == S_FAIL);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pend_q      <= 3'b000;
            cmd_byte_q  <= 8'h00;
            arg_byte_q  <= 8'h00;
            has_arg_q   <= 1'b0;
            is_reset_q  <= 1'b0;
            arg_phase_q <= 1'b0;
            retry_q     <= RW'(0);
            tmo_q       <= TW'(0);
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= 8'h00;
            busy_q      <= 1'b0;
            cmd_done_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            cmd_byte_q  <= cmd_byte_d;
            arg_byte_q  <= arg_byte_d;
            has_arg_q   <= has_arg_d;
            is_reset_q  <= is_reset_d;
            arg_phase_q <= arg_phase_d;
            retry_q     <= retry_d;
            tmo_q       <= tmo_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_data_q  <= fwd_data_d;
            busy_q      <= busy_d;
            cmd_done_q  <= cmd_done_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign fwd_valid = fwd_valid_q;
    assign fwd_data  = fwd_data_q;
    assign busy      = busy_q;
    assign cmd_done  = cmd_done_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// Directed + randomized bench for ps2_cmd_scheduler: the bench plays transmitter and keyboard
// and checks the byte stream, reply filtering, retries, timeouts and completion pulses.
module tb_ps2_cmd_scheduler;

    localparam int TMO   = 100;
    localparam int BAT   = 300;
    localparam int RETRY = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       req_reset;
    logic       req_led;
    logic [2:0] led_state;
    logic       req_rate;
    logic [7:0] rate_data;
    logic       fwd_valid;
    logic [7:0] fwd_data;
    logic       busy;
    logic       cmd_done;
    logic       cmd_err;

    ps2_cmd_scheduler #(
        .TIMEOUT_CYCLES    (TMO),
        .BAT_TIMEOUT_CYCLES(BAT),
        .MAX_RETRY         (RETRY)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_done  (rx_done),
        .rx_data  (rx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .req_reset(req_reset),
        .req_led  (req_led),
        .led_state(led_state),
        .req_rate (req_rate),
        .rate_data(rate_data),
        .fwd_valid(fwd_valid),
        .fwd_data (fwd_data),
        .busy     (busy),
        .cmd_done (cmd_done),
        .cmd_err  (cmd_err)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] tx_q[$];
    int         txc_q[$];
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         fwd_cnt = 0;
    int         exp_fwd = 0;
    int         base_d = 0;
    int         base_e = 0;
    int         last_done = 0;
    logic       busy_at_edge = 1'b0;
    logic       tx_open = 1'b0;

    logic [2:0] lv;
    logic [7:0] rv;
    int         t;
    int         d0;
    int         gap;
    logic [7:0] seq[6];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Edge-side view of the transmitter handshake
    always @(posedge clk) begin
        cyc = cyc + 1;
        busy_at_edge = tx_busy;
        if (tx_done || reset) tx_open = 1'b0;
    end

    // Collect transmitted bytes and completion/forward pulses
    always @(negedge clk) begin
        if (tx_start) begin
            check("tx_start_while_busy", {31'd0, busy_at_edge}, 32'd0);
            check("tx_start_twice", {31'd0, tx_open}, 32'd0);
            tx_open = 1'b1;
            tx_q.push_back(tx_data);
            txc_q.push_back(cyc);
        end
        if (cmd_done) done_cnt++;
        if (cmd_err) err_cnt++;
        if (fwd_valid) fwd_cnt++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic mark();
        base_d = done_cnt;
        base_e = err_cnt;
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic exp_f, input string tag);
        rx_data = b;
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
        check({tag, "_fwd_valid"}, {31'd0, fwd_valid}, {31'd0, exp_f});
        if (exp_f) begin
            check({tag, "_fwd_data"}, {24'd0, fwd_data}, {24'd0, b});
            exp_fwd++;
        end
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] exp, input int max_wait,
                             output int at);
        int w;
        w  = 0;
        at = -1;
        while (tx_q.size() == 0 && w < max_wait) begin
            step();
            w++;
        end
        if (tx_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: no tx_start within %0d cycles", tag, max_wait);
            return;
        end
        at = txc_q.pop_front();
        check(tag, {24'd0, tx_q.pop_front()}, {24'd0, exp});
        tx_busy = 1'b1;
        repeat (3) step();
        tx_done   = 1'b1;
        tx_busy   = 1'b0;
        last_done = cyc;
        step();
        tx_done = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int exp_d, input int exp_e, input int max_wait);
        int w;
        w = 0;
        while ((done_cnt + err_cnt) == (base_d + base_e) && w < max_wait) begin
            step();
            w++;
        end
        check({tag, "_done"}, done_cnt - base_d, exp_d);
        check({tag, "_err"}, err_cnt - base_e, exp_e);
        step();
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        rx_done   = 1'b0;
        rx_data   = 8'h00;
        tx_busy   = 1'b0;
        tx_done   = 1'b0;
        req_reset = 1'b0;
        req_led   = 1'b0;
        req_rate  = 1'b0;
        led_state = 3'b000;
        rate_data = 8'h00;

        repeat (3) step();
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        check("rst_fwd_data", {24'd0, fwd_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cmd_done", {31'd0, cmd_done}, 32'd0);
        check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        reset = 1'b0;
        step();

        // LED update, with the transmitter initially busy; led_state sampled at grant only
        mark();
        lv        = 3'($urandom_range(0, 7));
        led_state = lv;
        tx_busy   = 1'b1;
        req_led   = 1'b1;
        step();
        req_led = 1'b0;
        repeat (8) step();
        check("stall_no_tx", tx_q.size(), 32'd0);
        check("stall_busy", {31'd0, busy}, 32'd1);
        tx_busy   = 1'b0;
        led_state = ~lv;
        expect_tx("led_cmd", 8'hED, 20, t);
        rx_byte(8'hFA, 1'b0, "led_ack1");
        expect_tx("led_arg", {5'b00000, lv}, 20, t);
        rx_byte(8'hFA, 1'b0, "led_ack2");
        wait_result("led", 1, 0, 20);

        // Priority reset > led > rate; rate request arrives mid-command
        mark();
        lv        = 3'($urandom_range(0, 7));
        rv        = 8'($urandom);
        led_state = lv;
        rate_data = rv;
        req_led   = 1'b1;
        req_reset = 1'b1;
        step();
        req_led   = 1'b0;
        req_reset = 1'b0;
        expect_tx("prio_ff", 8'hFF, 20, t);
        rx_byte(8'hFA, 1'b0, "prio_ack");
        req_rate = 1'b1;
        step();
        req_rate = 1'b0;
        rx_byte(8'hAA, 1'b0, "prio_bat");
        wait_result("prio_reset", 1, 0, 20);
        mark();
        expect_tx("prio_ed", 8'hED, 20, t);
        rx_byte(8'hFA, 1'b0, "prio_led_ack1");
        expect_tx("prio_led_arg", {5'b00000, lv}, 20, t);
        rx_byte(8'hFA, 1'b0, "prio_led_ack2");
        wait_result("prio_led", 1, 0, 20);
        mark();
        expect_tx("prio_f3", 8'hF3, 20, t);
        rx_byte(8'hFA, 1'b0, "prio_rate_ack1");
        expect_tx("prio_rate_arg", rv, 20, t);
        rx_byte(8'hFA, 1'b0, "prio_rate_ack2");
        wait_result("prio_rate", 1, 0, 20);

        // Three resends then success
        mark();
        rate_data = 8'h20;
        req_rate  = 1'b1;
        step();
        req_rate = 1'b0;
        expect_tx("rs_f3", 8'hF3, 20, t);
        for (int i = 0; i < RETRY; i++) begin
            rx_byte(8'hFE, 1'b0, "rs_resend");
            expect_tx("rs_f3_again", 8'hF3, 20, t);
        end
        rx_byte(8'hFA, 1'b0, "rs_ack1");
        expect_tx("rs_arg", 8'h20, 20, t);
        rx_byte(8'hFA, 1'b0, "rs_ack2");
        wait_result("rs_ok", 1, 0, 20);

        // Four resends abort the command
        mark();
        rate_data = 8'($urandom);
        req_rate  = 1'b1;
        step();
        req_rate = 1'b0;
        expect_tx("rsx_f3", 8'hF3, 20, t);
        for (int i = 0; i <= RETRY; i++) begin
            rx_byte(8'hFE, 1'b0, "rsx_resend");
            if (i < RETRY) expect_tx("rsx_f3_again", 8'hF3, 20, t);
        end
        wait_result("rsx_abort", 0, 1, 20);
        repeat (10) step();
        check("rsx_no_tx", tx_q.size(), 32'd0);

        // Silent device: resend every TMO cycles, four transmissions, then error
        mark();
        led_state = 3'($urandom_range(0, 7));
        req_led   = 1'b1;
        step();
        req_led = 1'b0;
        expect_tx("tmo_ed0", 8'hED, 20, t);
        for (int k = 1; k <= RETRY; k++) begin
            d0 = last_done;
            expect_tx("tmo_ed", 8'hED, TMO + 50, t);
            gap = t - d0;
            check("tmo_gap_min", {31'd0, gap >= TMO}, 32'd1);
            check("tmo_gap_max", {31'd0, gap <= TMO + 10}, 32'd1);
        end
        wait_result("tmo_abort", 0, 1, TMO + 50);
        repeat (10) step();
        check("tmo_no_tx", tx_q.size(), 32'd0);

        // Back-to-back scan codes in IDLE, including prefixes and a stray ACK
        seq[0] = 8'h1D;
        seq[1] = 8'hF0;
        seq[2] = 8'h1D;
        seq[3] = 8'hFA;
        seq[4] = 8'($urandom);
        seq[5] = 8'($urandom);
        rx_data = seq[0];
        rx_done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i < 5) rx_data = seq[i + 1];
            else rx_done = 1'b0;
            check("fwd_seq_valid", {31'd0, fwd_valid}, 32'd1);
            check("fwd_seq_data", {24'd0, fwd_data}, {24'd0, seq[i]});
            exp_fwd++;
        end

        // Scan code during WAIT_ACK is forwarded, the ACK is not
        mark();
        rv        = 8'($urandom);
        rate_data = rv;
        req_rate  = 1'b1;
        step();
        req_rate = 1'b0;
        expect_tx("wa_f3", 8'hF3, 20, t);
        rx_byte(8'h1C, 1'b1, "wa_scan");
        rx_byte(8'hFA, 1'b0, "wa_ack1");
        expect_tx("wa_arg", rv, 20, t);
        rx_byte(8'hFA, 1'b0, "wa_ack2");
        wait_result("wa", 1, 0, 20);

        // Self-test failure reply
        mark();
        req_reset = 1'b1;
        step();
        req_reset = 1'b0;
        expect_tx("bat_ff", 8'hFF, 20, t);
        rx_byte(8'hFA, 1'b0, "bat_ack");
        rx_byte(8'hFC, 1'b0, "bat_fail");
        wait_result("bat_fail", 0, 1, 20);

        // Reset while waiting for an ACK, with another request pending
        mark();
        req_led = 1'b1;
        step();
        req_led = 1'b0;
        expect_tx("mid_ed", 8'hED, 20, t);
        req_rate = 1'b1;
        step();
        req_rate = 1'b0;
        reset    = 1'b1;
        step();
        check("mid_busy", {31'd0, busy}, 32'd0);
        step();
        reset = 1'b0;
        repeat (30) step();
        check("mid_no_tx", tx_q.size(), 32'd0);
        check("mid_idle", {31'd0, busy}, 32'd0);
        check("mid_no_done", done_cnt - base_d, 32'd0);
        check("mid_no_err", err_cnt - base_e, 32'd0);
        mark();
        req_reset = 1'b1;
        step();
        req_reset = 1'b0;
        expect_tx("post_ff", 8'hFF, 20, t);
        rx_byte(8'hFA, 1'b0, "post_ack");
        rx_byte(8'hAA, 1'b0, "post_bat");
        wait_result("post", 1, 0, 20);

        repeat (5) step();
        check("fwd_total", fwd_cnt, exp_fwd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
